seg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the six-digit 12-hour clock display (HH MM SS). Each cycle period it selects one digit position, presents that digit's 4-bit code to the downstream BCD-to-7-segment decoder, and drives the active-low digit enables. An all-off guard gap separates digits to prevent ghosting. It also blanks the leading hour zero and blinks the field being set.

---
 rtl/seg_scan_ctrl_pkg.sv | 22 ++
 rtl/seg_scan_ctrl_prescaler.sv | 37 +++
 rtl/seg_scan_ctrl.sv | 166 ++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_ctrl_pkg.sv
// Shared encodings for the six-digit display scan controller.
package seg_scan_ctrl_pkg;

  localparam logic [1:0] ST_OFF  = 2'd0;
  localparam logic [1:0] ST_SHOW = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam logic [5:0] ALL_OFF_N  = 6'h3F;

  localparam logic [1:0] BLINK_NONE = 2'b00;
  localparam logic [1:0] BLINK_HOUR = 2'b01;
  localparam logic [1:0] BLINK_MIN  = 2'b10;
  localparam logic [1:0] BLINK_SEC  = 2'b11;

  localparam logic [2:0] LAST_IDX = 3'd5;

  function automatic logic [5:0] digit_enable_n(input logic [2:0] idx);
    return ~(6'b00_0001 << idx);
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_prescaler.sv
// Loadable down-counter; terminal count when it reaches zero.
module scan_prescaler #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Load wins over counting; the counter parks at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Six-digit HH MM SS scan controller: guard gaps, leading-zero blanking, field blink.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int CLK_DIV      = 1000,
  parameter int GAP_CYC      = 16,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] hour,
  input  logic [7:0] min_bcd,
  input  logic [7:0] sec_bcd,
  input  logic [1:0] blink_sel,
  output logic [3:0] digit_code,
  output logic [5:0] digit_sel_n,
  output logic       frame_tick
);

  localparam int CNT_MAX = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
  localparam int CW      = $clog2(CNT_MAX) + 1;
  localparam int BW      = $clog2(BLINK_FRAMES) + 1;

  logic [1:0]    state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          bph_q, bph_d;
  logic [3:0]    code_q, code_d;
  logic [5:0]    sel_q, sel_d;
  logic          tick_q, tick_d;

  logic          tc_s;
  logic          load_s;
  logic [CW-1:0] load_val_s;
  logic          show_entry_s;
  logic          frame_end_s;
  logic          blink_hit_s;
  logic [3:0]    pos_code_s;

  scan_prescaler #(.W(CW)) u_prescaler (
    .clk        (clk),
    .rst_n      (rst),
    .load_i     (load_s),
    .load_val_i (load_val_s),
    .tc_o       (tc_s)
  );

  // Scan sequencing; dropping en overrides every state.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (!en) begin
      state_d = ST_OFF;
      idx_d   = 3'd0;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d = ST_SHOW;
          idx_d   = 3'd0;
        end
        ST_SHOW: begin
          if (tc_s) begin
            state_d = ST_GAP;
          end else begin
            state_d = ST_SHOW;
          end
        end
        ST_GAP: begin
          if (tc_s) begin
            state_d = ST_SHOW;
            idx_d   = (idx_q == LAST_IDX) ? 3'd0 : idx_q + 3'd1;
          end else begin
            state_d = ST_GAP;
          end
        end
        default: begin
          state_d = ST_OFF;
          idx_d   = 3'd0;
        end
      endcase
    end
  end

  assign show_entry_s = (state_d == ST_SHOW) && (state_q != ST_SHOW);
  assign frame_end_s  = en && (state_q == ST_SHOW) && tc_s && (idx_q == LAST_IDX);
  assign load_s       = (state_d != state_q);

  // Every state change reloads the duration of the state being entered.
  always_comb begin
    case (state_d)
      ST_SHOW: load_val_s = CW'(CLK_DIV - 1);
      ST_GAP:  load_val_s = CW'(GAP_CYC - 1);
      default: load_val_s = '0;
    endcase
  end

  always_comb begin
    bcnt_d = bcnt_q;
    bph_d  = bph_q;
    if (frame_end_s) begin
      if (bcnt_q == BW'(BLINK_FRAMES - 1)) begin
        bcnt_d = '0;
        bph_d  = ~bph_q;
      end else begin
        bcnt_d = bcnt_q + BW'(1);
      end
    end else begin
      bcnt_d = bcnt_q;
    end
  end

  // Codes 10..12 in the hour-ones slot pass through for the decoder to fold.
  always_comb begin
    case (idx_d)
      3'd0:    pos_code_s = ((hour >= 4'd10) && (hour <= 4'd12)) ? 4'd1 : BLANK_CODE;
      3'd1:    pos_code_s = (hour <= 4'd12) ? hour : BLANK_CODE;
      3'd2:    pos_code_s = min_bcd[7:4];
      3'd3:    pos_code_s = min_bcd[3:0];
      3'd4:    pos_code_s = sec_bcd[7:4];
      3'd5:    pos_code_s = sec_bcd[3:0];
      default: pos_code_s = BLANK_CODE;
    endcase
  end

  // Pair index idx[2:1] lines up with blink_sel-1 for the three fields.
  assign blink_hit_s = bph_q && (blink_sel != BLINK_NONE) &&
                       (idx_d[2:1] == (blink_sel - 2'd1));

  always_comb begin
    sel_d  = (state_d == ST_SHOW) ? digit_enable_n(idx_d) : ALL_OFF_N;
    tick_d = frame_end_s;
    if (state_d == ST_OFF) begin
      code_d = BLANK_CODE;
    end else if (show_entry_s) begin
      code_d = blink_hit_s ? BLANK_CODE : pos_code_s;
    end else begin
      code_d = code_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_OFF;
      idx_q   <= 3'd0;
      bcnt_q  <= '0;
      bph_q   <= 1'b0;
      code_q  <= BLANK_CODE;
      sel_q   <= ALL_OFF_N;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      bph_q   <= bph_d;
      code_q  <= code_d;
      sel_q   <= sel_d;
      tick_q  <= tick_d;
    end
  end

  assign digit_code  = code_q;
  assign digit_sel_n = sel_q;
  assign frame_tick  = tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized scoreboard bench for seg_scan_ctrl with a time-slot reference model.
module tb_seg_scan_ctrl;

  localparam int D  = 4;
  localparam int G  = 2;
  localparam int BF = 2;
  localparam int P  = D + G;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] hour;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic [1:0] blink_sel;
  logic [3:0] digit_code;
  logic [5:0] digit_sel_n;
  logic       frame_tick;

  typedef struct {
    logic [5:0] sel;
    logic [3:0] code;
    logic       tick;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model state: cycles since scanning began, completed frames since reset.
  int         m_run = 0;
  int         m_t = 0;
  int         m_frames = 0;
  logic [3:0] m_code = 4'hF;

  seg_scan_ctrl #(.CLK_DIV(D), .GAP_CYC(G), .BLINK_FRAMES(BF)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .hour        (hour),
    .min_bcd     (min_bcd),
    .sec_bcd     (sec_bcd),
    .blink_sel   (blink_sel),
    .digit_code  (digit_code),
    .digit_sel_n (digit_sel_n),
    .frame_tick  (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int m_ph();
    return m_t % P;
  endfunction

  function automatic int m_idx();
    return (m_t / P) % 6;
  endfunction

  function automatic logic [3:0] ref_code(input int pos, input bit blanked);
    int v;
    int hr;
    int mn;
    int sc;
    hr = int'(hour);
    mn = int'(min_bcd);
    sc = int'(sec_bcd);
    case (pos)
      0:       v = (hr >= 10 && hr <= 12) ? 1 : 15;
      1:       v = (hr <= 12) ? hr : 15;
      2:       v = mn / 16;
      3:       v = mn % 16;
      4:       v = sc / 16;
      default: v = sc % 16;
    endcase
    if (blanked && blink_sel != 2'b00 && (pos / 2) == int'(blink_sel) - 1) v = 15;
    return v[3:0];
  endfunction

  // Predict the cycle that follows the next edge, then queue it once the edge happens.
  task automatic cycle();
    exp_t e;
    int   ph;
    int   idx;
    e.sel  = 6'h3F;
    e.tick = 1'b0;
    if (!rst) begin
      m_run = 0; m_frames = 0; m_code = 4'hF;
    end else if (!en) begin
      m_run = 0; m_code = 4'hF;
    end else if (m_run == 0) begin
      m_run = 1; m_t = 0;
    end else begin
      m_t++;
    end
    if (m_run != 0) begin
      ph  = m_ph();
      idx = m_idx();
      if (ph == 0) m_code = ref_code(idx, ((m_frames / BF) % 2) == 1);
      if (ph < D) e.sel = 6'h3F ^ (6'd1 << idx);
      if (ph == D && idx == 5) begin
        e.tick = 1'b1;
        m_frames++;
      end
    end
    e.code = m_code;
    @(posedge clk);
    sbq.push_back(e);
    #1;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  // Monitor: every presented output cycle is popped and compared.
  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      check("digit_sel_n", 32'(digit_sel_n), 32'(e.sel));
      check("digit_code", 32'(digit_code), 32'(e.code));
      check("frame_tick", 32'(frame_tick), 32'(e.tick));
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; hour = 4'd0; min_bcd = 8'h00; sec_bcd = 8'h00; blink_sel = 2'b00;
    #2 rst = 1'b0;
    #1;
    check("reset_sel", 32'(digit_sel_n), 32'h3F);
    check("reset_code", 32'(digit_code), 32'hF);
    check("reset_tick", 32'(frame_tick), 32'h0);
    run(2);
    rst = 1'b1;
    run(2);

    // Basic scan of 9:35:07, then hour boundary values.
    hour = 4'd9; min_bcd = 8'h35; sec_bcd = 8'h07; en = 1'b1;
    run(2 * 6 * P);
    hour = 4'd12;
    run(6 * P);
    hour = 4'd13;
    run(6 * P);
    hour = 4'd10;
    run(6 * P);

    // Minute blink across eight frames.
    hour = 4'd9; blink_sel = 2'b10;
    run(8 * 6 * P);
    blink_sel = 2'b00;

    // Drop en in the middle of position 3 SHOW, then re-enable.
    for (int k = 0; k < 200 && !(m_run != 0 && m_idx() == 3 && m_ph() == 1); k++) cycle();
    en = 1'b0;
    run(3);
    en = 1'b1;
    run(2 * 6 * P);

    // Change seconds mid-position-5 SHOW; held until the next entry.
    for (int k = 0; k < 200 && !(m_run != 0 && m_idx() == 5 && m_ph() == 1); k++) cycle();
    sec_bcd = 8'h59;
    run(2 * 6 * P);

    // Asynchronous reset between edges while in GAP.
    for (int k = 0; k < 200 && !(m_run != 0 && m_ph() >= D); k++) cycle();
    #1 rst = 1'b0;
    #1;
    check("async_rst_sel", 32'(digit_sel_n), 32'h3F);
    check("async_rst_code", 32'(digit_code), 32'hF);
    check("async_rst_tick", 32'(frame_tick), 32'h0);
    sbq.delete();
    run(2);
    rst = 1'b1;
    run(2 * 6 * P);

    // Randomized inputs, enable toggling and blink selection.
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 19) == 0) hour = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) min_bcd = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 19) == 0) sec_bcd = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 99) == 0) blink_sel = 2'($urandom_range(0, 3));
      if (!en) en = ($urandom_range(0, 3) == 0);
      else if ($urandom_range(0, 199) == 0) en = 1'b0;
      cycle();
    end

    en = 1'b0;
    run(3);
    @(negedge clk);
    #1;
    check("queue_drained", 32'(sbq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
